truth_table_capture: RTL and testbench
======================================

TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 Parameter SETTLE, default 2: clock cycles each input vector is held before f is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a sweep.
REQ-005 expected  input  16  golden truth table; bit i is the required f for vector i.
REQ-006 f  input  1  response of the combinational unit under test.
REQ-007 abcd  output  4  vector driven to the unit under test; bit 3 = A, bit 0 = D.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high from sweep completion until the next accepted start.
REQ-010 pass  output  1  valid while done; high when captured table equals the latched expected table.
REQ-011 captured  output  16  observed truth table; bit i = f sampled for vector i.
REQ-012 mismatch_count  output  5  number of differing bits, 0..16.
REQ-013 first_fail  output  4  lowest failing vector index; 0 when pass is high.

Function
REQ-014 The block SHALL be a Moore FSM; all outputs are registered and depend on state only.
REQ-015 States SHALL be IDLE, SWEEP, COMPARE and DONE.
- IDLE -> SWEEP on start.
- SWEEP -> COMPARE after vector 15 is sampled.
- COMPARE -> DONE after exactly one cycle.
- DONE -> SWEEP on start.
REQ-016 On an accepted start, expected SHALL be latched, captured and mismatch_count cleared, and abcd set to 0 on the next edge.
REQ-017 In SWEEP, each vector SHALL be held for SETTLE cycles; f SHALL be sampled into captured[abcd] on the last of those cycles.
REQ-018 abcd SHALL then increment by one; vectors are applied in order 0..15.
REQ-019 abcd SHALL hold 15 through COMPARE and DONE; it SHALL NOT wrap to 0 until the next start.
REQ-020 busy SHALL be high in SWEEP and COMPARE.
REQ-021 A start that is asserted while busy is high SHALL be ignored.
REQ-022 In COMPARE, mismatch_count SHALL be set to the population count of (captured XOR latched expected).
REQ-023 In COMPARE, first_fail SHALL be set to the lowest set bit of that XOR.
REQ-024 pass SHALL be set to (mismatch_count == 0).
REQ-025 done SHALL rise exactly 16*SETTLE + 2 cycles after the edge that accepts start.
REQ-026 Changes on expected after start is accepted SHALL NOT affect the result.

Reset
REQ-027 Reset SHALL immediately force:
- state to IDLE;
- abcd, captured, mismatch_count and first_fail to 0;
- busy, done and pass to 0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no partial result retained.
REQ-029 The first start after reset is deasserted SHALL be honoured normally.

Structure
REQ-030 The state encodings, NUM_VECTORS = 16 and the SETTLE range limits SHALL live in a shared package/include.
REQ-031 The settle timer plus vector index SHALL be one sub-module, sweep_counter, with the following ports:
- inputs clear and enable;
- outputs index[3:0], sample_now and last.

Verification
REQ-032 Model f as minterms {0,2,5,7,11,14}, set expected = 16'h48A5, pulse start -> required response:
- captured = 16'h48A5;
- pass = 1 and mismatch_count = 0;
- done rises at cycle 34 with SETTLE = 2.
REQ-033 Same model with expected = 16'h48A4 -> pass = 0, mismatch_count = 1, first_fail = 0.
REQ-034 Model f tied to 1 with expected = 16'h0000 -> captured = 16'hFFFF, mismatch_count = 16, first_fail = 0.
REQ-035 Assert reset while abcd = 7 -> required response:
- abcd, busy, done and captured all go to 0 immediately;
- a following start completes a full, correct sweep.
REQ-036 Pulse start during SWEEP and change expected during SWEEP -> the sweep timing and the result are unchanged.
REQ-037 With SETTLE = 1, each abcd value SHALL be held for exactly 1 cycle and done SHALL rise at cycle 18.

Source files
------------

// File: rtl/truth_table_capture_pkg.sv
// Shared definitions for the truth-table capture block: FSM encoding,
// sweep geometry and the reduction helpers used at compare time.
package truth_table_capture_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int SETTLE_MIN  = 1;
  localparam int SETTLE_MAX  = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_VECTORS; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

  // Lowest set bit index; 0 when nothing is set.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/truth_table_capture_if.sv
// Stimulus/result bundle between the capture block and its driver.
interface truth_table_capture_if;
  import truth_table_capture_pkg::*;

  logic        start;
  logic [15:0] expected;
  logic        f;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;

  modport master (
    output start, expected, f,
    input  abcd, busy, done, pass, captured, mismatch_count, first_fail
  );

  modport slave (
    input  start, expected, f,
    output abcd, busy, done, pass, captured, mismatch_count, first_fail
  );
endinterface

// File: rtl/truth_table_capture_sweep_counter.sv
// Settle timer plus vector index: holds each vector SETTLE cycles, flags the
// sampling cycle, and parks on the final vector instead of wrapping.
module sweep_counter
  import truth_table_capture_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] index,
  output logic       sample_now,
  output logic       last
);

  logic [3:0] timer;

  assign sample_now = enable && (timer == 4'(SETTLE - 1));
  assign last       = sample_now && (index == 4'(NUM_VECTORS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
      index <= '0;
    end else if (clear) begin
      timer <= '0;
      index <= '0;
    end else if (enable) begin
      if (sample_now) begin
        timer <= '0;
        if (!last) index <= index + 4'd1;
      end else begin
        timer <= timer + 4'd1;
      end
    end
  end

endmodule

// File: rtl/truth_table_capture.sv
// Exhaustive 4-input truth-table sweep of an external combinational unit,
// compared against a golden table latched at start.
module truth_table_capture
  import truth_table_capture_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input logic                  clk,
  input logic                  reset,
  truth_table_capture_if.slave bus
);

  state_t      state;
  logic [15:0] exp_q;
  logic [15:0] captured_q;
  logic [4:0]  mismatch_q;
  logic [3:0]  first_fail_q;
  logic        busy_q, done_q, pass_q;

  logic [3:0]  index;
  logic        sample_now, last;
  logic        accept;
  logic [15:0] diff;

  // A start is only honoured while no sweep is in flight.
  assign accept = bus.start && (state == IDLE || state == DONE);
  assign diff   = captured_q ^ exp_q;

  sweep_counter #(.SETTLE(SETTLE)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .enable     (state == SWEEP),
    .index      (index),
    .sample_now (sample_now),
    .last       (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      exp_q        <= '0;
      captured_q   <= '0;
      mismatch_q   <= '0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state        <= SWEEP;
            exp_q        <= bus.expected;
            captured_q   <= '0;
            mismatch_q   <= '0;
            first_fail_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end else if (state == DONE) begin
            // Verdict follows the registered count one cycle after COMPARE.
            done_q <= 1'b1;
            pass_q <= (mismatch_q == 5'd0);
          end
        end
        SWEEP: begin
          if (sample_now) captured_q[index] <= bus.f;
          if (last) state <= COMPARE;
        end
        COMPARE: begin
          mismatch_q   <= popcount16(diff);
          first_fail_q <= lowest_set(diff);
          busy_q       <= 1'b0;
          state        <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.abcd           = index;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.captured       = captured_q;
  assign bus.mismatch_count = mismatch_q;
  assign bus.first_fail     = first_fail_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench: stimulus pushes expected sweep results, a monitor per DUT
// pops and checks them when done rises.
module tb_truth_table_capture;
  import truth_table_capture_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_capture_if ifa();
  truth_table_capture_if ifb();

  truth_table_capture #(.SETTLE(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  truth_table_capture #(.SETTLE(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Unit under test model: minterms {0,2,5,7,11,14} or constant 1.
  logic [15:0] f_tbl = 16'h48A5;
  logic        f_one = 1'b0;
  assign ifa.f = f_one ? 1'b1 : f_tbl[ifa.abcd];
  assign ifb.f = f_one ? 1'b1 : f_tbl[ifb.abcd];

  typedef struct {
    logic [15:0] cap;
    logic        pass;
    logic [4:0]  mc;
    logic [3:0]  ff;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic monitor(input int s);
    logic done_prev = 1'b0;
    int   acc = 0;
    exp_t e;
    logic st, bz, dn, ps;
    logic [15:0] cp;
    logic [4:0]  mc;
    logic [3:0]  ff;
    forever begin
      @(negedge clk);
      st = s ? ifb.start : ifa.start;
      bz = s ? ifb.busy  : ifa.busy;
      dn = s ? ifb.done  : ifa.done;
      ps = s ? ifb.pass  : ifa.pass;
      cp = s ? ifb.captured : ifa.captured;
      mc = s ? ifb.mismatch_count : ifa.mismatch_count;
      ff = s ? ifb.first_fail : ifa.first_fail;
      if (st && !bz && !reset) acc = cyc + 1;
      if (dn && !done_prev) begin
        if ((s ? qb.size() : qa.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done dut%0d", s);
        end else begin
          e = s ? qb.pop_front() : qa.pop_front();
          chk(s ? "b_captured" : "a_captured", 32'(cp), 32'(e.cap));
          chk(s ? "b_pass"     : "a_pass",     32'(ps), 32'(e.pass));
          chk(s ? "b_mismatch" : "a_mismatch", 32'(mc), 32'(e.mc));
          chk(s ? "b_firstfail": "a_firstfail",32'(ff), 32'(e.ff));
          chk(s ? "b_latency"  : "a_latency",  32'(cyc - acc), 32'(e.lat));
        end
      end
      done_prev = dn;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int s, input logic [15:0] ev);
    if (s) begin ifb.expected = ev; ifb.start = 1'b1; end
    else   begin ifa.expected = ev; ifa.start = 1'b1; end
    tick();
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic wait_drain(input int s);
    int i;
    for (i = 0; i < 200 && (s ? qb.size() : qa.size()) != 0; i++) tick();
    if ((s ? qb.size() : qa.size()) != 0) begin
      total++;
      bad++;
      $display("FAIL timeout_dut%0d: got pending want empty", s);
      if (s) qb.delete(); else qa.delete();
    end
  endtask

  task automatic run(input int s, input logic [15:0] ev, input logic one,
                     input logic [15:0] cap, input logic ps, input logic [4:0] mc,
                     input logic [3:0] ff);
    exp_t e;
    e.cap = cap; e.pass = ps; e.mc = mc; e.ff = ff;
    e.lat = s ? 18 : 34;
    f_one = one;
    if (s) qb.push_back(e); else qa.push_back(e);
    pulse_start(s, ev);
    wait_drain(s);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    ifa.start = 1'b0; ifa.expected = '0;
    ifb.start = 1'b0; ifb.expected = '0;
    fork
      monitor(0);
      monitor(1);
    join_none
    repeat (3) tick();
    chk("rst_abcd",     32'(ifa.abcd), 0);
    chk("rst_busy",     32'(ifa.busy), 0);
    chk("rst_done",     32'(ifa.done), 0);
    chk("rst_pass",     32'(ifa.pass), 0);
    chk("rst_captured", 32'(ifa.captured), 0);
    chk("rst_mismatch", 32'(ifa.mismatch_count), 0);
    chk("rst_firstfail",32'(ifa.first_fail), 0);
    reset = 1'b0;
    tick();

    run(0, 16'h48A5, 1'b0, 16'h48A5, 1'b1, 5'd0,  4'd0);
    chk("hold_abcd_15", 32'(ifa.abcd), 15);
    chk("done_not_busy", 32'(ifa.busy), 0);
    run(0, 16'h48A4, 1'b0, 16'h48A5, 1'b0, 5'd1,  4'd0);
    run(0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 5'd16, 4'd0);
    run(0, 16'hC8A5, 1'b0, 16'h48A5, 1'b0, 5'd1,  4'd15);
    run(0, 16'hB75A, 1'b0, 16'h48A5, 1'b0, 5'd16, 4'd0);
    run(0, 16'h4995, 1'b0, 16'h48A5, 1'b0, 5'd3,  4'd4);

    // Abort a sweep part-way; nothing must survive.
    f_one = 1'b0;
    pulse_start(0, 16'h48A5);
    for (k = 0; k < 100 && ifa.abcd != 4'd7; k++) tick();
    chk("reach_abcd7", 32'(ifa.abcd), 7);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_abcd",     32'(ifa.abcd), 0);
    chk("abort_busy",     32'(ifa.busy), 0);
    chk("abort_done",     32'(ifa.done), 0);
    chk("abort_captured", 32'(ifa.captured), 0);
    tick();
    reset = 1'b0;
    tick();
    run(0, 16'h48A5, 1'b0, 16'h48A5, 1'b1, 5'd0, 4'd0);

    // Re-start and expected churn mid-sweep must be invisible.
    begin
      exp_t e;
      e.cap = 16'h48A5; e.pass = 1'b1; e.mc = 5'd0; e.ff = 4'd0; e.lat = 34;
      qa.push_back(e);
      pulse_start(0, 16'h48A5);
      repeat (6) tick();
      pulse_start(0, 16'h0000);
      repeat (4) tick();
      ifa.expected = 16'hFFFF;
      wait_drain(0);
    end

    // SETTLE = 1: one cycle per vector.
    begin
      exp_t e;
      e.cap = 16'h48A5; e.pass = 1'b1; e.mc = 5'd0; e.ff = 4'd0; e.lat = 18;
      qb.push_back(e);
      f_one = 1'b0;
      ifb.expected = 16'h48A5;
      ifb.start = 1'b1;
      tick();
      ifb.start = 1'b0;
      for (int v = 0; v < 16; v++) begin
        chk("b_abcd_step", 32'(ifb.abcd), 32'(v));
        tick();
      end
      wait_drain(1);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
